// File: rtl/tff_count_ctrl.sv
// Sequencing controller for an internal bank of toggle flip-flops that counts
// up or down from its current value to a captured terminal value.
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] term,
    input  logic             clr,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] term_r;
    logic             dir_r;
    logic [WIDTH-1:0] step_en;
    logic             at_term;

    assign at_term = (q == term_r);

    // Bit i toggles when every lower bit is 1 (up) or 0 (down): a ripple
    // carry/borrow chain. Wrap-around falls out naturally as all-ones.
    always_comb begin : step_calc
        logic carry;
        // NOTE: every combinationally assigned variable gets a default first,
        // so no path through the block can leave it unassigned and infer a latch.
        carry   = 1'b1;
        step_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            step_en[i] = carry;
            carry      = carry & (dir_r ? q[i] : ~q[i]);
        end
    end

    always_comb begin
        t_en = '0;
        case (state)
            IDLE:    t_en = clr ? q : '0;
            RUN:     t_en = (stop || at_term) ? '0 : step_en;
            default: t_en = '0;
        endcase
    end

    // The toggle bank itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            q <= q ^ t_en;
        end
    end

    // Controller FSM; busy and done are registered alongside the state so
    // they are clean decodes with no combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            term_r <= '0;
            dir_r  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !clr) begin
                        term_r <= term;
                        dir_r  <= up_dn;
                        state  <= RUN;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (at_term) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
